// File: rtl/serial_slice_bridge_pkg.sv
// Shared types and elaboration helpers for the parallel<->slice-serial bridge.
package serial_slice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int unsigned nsl(input int unsigned xlen, input int unsigned slice_w);
    return xlen / slice_w;
  endfunction

  // A single-slice configuration still needs a 1-bit index port.
  function automatic int unsigned idx_w(input int unsigned xlen, input int unsigned slice_w);
    return (nsl(xlen, slice_w) > 1) ? unsigned'($clog2(nsl(xlen, slice_w))) : 1;
  endfunction

  function automatic bit legal_slice_w(input int unsigned slice_w);
    return (slice_w == 1) || (slice_w == 2) || (slice_w == 4) || (slice_w == 8);
  endfunction

endpackage

// File: rtl/serial_slice_bridge_if.sv
// Operand, slice and result handshake bundle between the bridge and its environment.
interface serial_slice_bridge_if
  import serial_slice_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SLICE_W = 4,
  parameter int unsigned N_IN    = 3,
  parameter int unsigned N_OUT   = 1,
  parameter int unsigned IW      = idx_w(XLEN, SLICE_W)
);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_IN*XLEN-1:0]     in_data;
  logic                     abort;
  logic [N_IN*SLICE_W-1:0]  slice_out;
  logic [IW-1:0]            slice_idx;
  logic                     slice_act;
  logic                     slice_last;
  logic [N_OUT*SLICE_W-1:0] core_res;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_OUT*XLEN-1:0]    out_data;

  modport slave (
    input  in_valid, in_data, abort, core_res, out_ready,
    output in_ready, slice_out, slice_idx, slice_act, slice_last, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, abort, core_res, out_ready,
    input  in_ready, slice_out, slice_idx, slice_act, slice_last, out_valid, out_data
  );

endinterface

// File: rtl/serial_slice_bridge_slice_shift_reg.sv
// One XLEN-bit register with full-word load plus indexed slice read and write.
module slice_shift_reg
  import serial_slice_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SLICE_W = 4,
  parameter int unsigned IW      = idx_w(XLEN, SLICE_W)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               ld_i,
  input  logic [XLEN-1:0]    ld_data_i,
  input  logic               wr_i,
  input  logic [IW-1:0]      wr_idx_i,
  input  logic [SLICE_W-1:0] wr_slice_i,
  input  logic [IW-1:0]      rd_idx_i,
  output logic [SLICE_W-1:0] rd_slice_o,
  output logic [XLEN-1:0]    q_o
);

  localparam int unsigned NSL = nsl(XLEN, SLICE_W);

  logic [NSL-1:0][SLICE_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q <= '0;
    end else if (ld_i) begin
      q_q <= ld_data_i;
    end else if (wr_i) begin
      for (int unsigned s = 0; s < NSL; s++) begin
        if (wr_idx_i == IW'(s)) q_q[s] <= wr_slice_i;
      end
    end
  end

  // Compare-select keeps the read safe when NSL is not a power of two.
  always_comb begin
    rd_slice_o = '0;
    for (int unsigned s = 0; s < NSL; s++) begin
      if (rd_idx_i == IW'(s)) rd_slice_o = q_q[s];
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_slice_bridge.sv
// Latches N_IN operands, streams them LSB-first SLICE_W bits per cycle and
// reassembles N_OUT core result slices into words, with abort and back-to-back reuse.
module serial_slice_bridge
  import serial_slice_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SLICE_W = 4,
  parameter int unsigned N_IN    = 3,
  parameter int unsigned N_OUT   = 1
) (
  input logic                 clk,
  input logic                 rstn,
  serial_slice_bridge_if.slave bus
);

  localparam int unsigned NSL = nsl(XLEN, SLICE_W);
  localparam int unsigned IW  = idx_w(XLEN, SLICE_W);

  if (XLEN % SLICE_W != 0) begin : g_bad_xlen
    $error("serial_slice_bridge: XLEN must be a multiple of SLICE_W");
  end
  if (!legal_slice_w(SLICE_W)) begin : g_bad_slice_w
    $error("serial_slice_bridge: SLICE_W must be 1, 2, 4 or 8");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          shifting;
  logic          last;
  logic          in_ready;
  logic          accept;

  assign shifting = (state_q == ST_SHIFT);
  assign last     = shifting && (idx_q == IW'(NSL - 1));
  // Abort masks acceptance so a coincident in_valid is dropped.
  assign in_ready = !bus.abort &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_SHIFT;
            idx_d   = '0;
          end
        end
        ST_SHIFT: begin
          idx_d = last ? '0 : idx_q + 1'b1;
          if (last) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = accept ? ST_SHIFT : ST_IDLE;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  logic [N_IN*SLICE_W-1:0]  slice_out_w;
  logic [N_IN*XLEN-1:0]     op_word;
  logic [N_OUT*SLICE_W-1:0] res_rd;
  logic [N_OUT*XLEN-1:0]    res_word;

  for (genvar k = 0; k < N_IN; k++) begin : g_op
    slice_shift_reg #(
      .XLEN    (XLEN),
      .SLICE_W (SLICE_W),
      .IW      (IW)
    ) u_op (
      .clk        (clk),
      .rstn       (rstn),
      .ld_i       (accept),
      .ld_data_i  (bus.in_data[k*XLEN +: XLEN]),
      .wr_i       (1'b0),
      .wr_idx_i   ('0),
      .wr_slice_i ('0),
      .rd_idx_i   (idx_q),
      .rd_slice_o (slice_out_w[k*SLICE_W +: SLICE_W]),
      .q_o        (op_word[k*XLEN +: XLEN])
    );
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_res
    slice_shift_reg #(
      .XLEN    (XLEN),
      .SLICE_W (SLICE_W),
      .IW      (IW)
    ) u_res (
      .clk        (clk),
      .rstn       (rstn),
      .ld_i       (1'b0),
      .ld_data_i  ('0),
      .wr_i       (shifting),
      .wr_idx_i   (idx_q),
      .wr_slice_i (bus.core_res[k*SLICE_W +: SLICE_W]),
      .rd_idx_i   (idx_q),
      .rd_slice_o (res_rd[k*SLICE_W +: SLICE_W]),
      .q_o        (res_word[k*XLEN +: XLEN])
    );
  end

  logic unused_bits;
  assign unused_bits = ^{op_word, res_rd};

  assign bus.in_ready   = in_ready;
  assign bus.slice_out  = slice_out_w;
  assign bus.slice_idx  = idx_q;
  assign bus.slice_act  = shifting;
  assign bus.slice_last = last;
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_data   = res_word;

endmodule

// File: tb/tb_serial_slice_bridge.sv
// Randomized self-checking bench: default config in detail plus SLICE_W=1 and 8 loopback sweeps.
module tb_serial_slice_bridge;

  logic clk;
  logic rstn;
  int   nchk = 0;
  int   nerr = 0;

  serial_slice_bridge_if #(.XLEN(32), .SLICE_W(4), .N_IN(3), .N_OUT(1)) bm ();
  serial_slice_bridge_if #(.XLEN(32), .SLICE_W(1), .N_IN(3), .N_OUT(1)) b1 ();
  serial_slice_bridge_if #(.XLEN(32), .SLICE_W(8), .N_IN(3), .N_OUT(1)) b8 ();

  serial_slice_bridge #(.XLEN(32), .SLICE_W(4), .N_IN(3), .N_OUT(1)) u_m (
    .clk(clk), .rstn(rstn), .bus(bm));
  serial_slice_bridge #(.XLEN(32), .SLICE_W(1), .N_IN(3), .N_OUT(1)) u_w1 (
    .clk(clk), .rstn(rstn), .bus(b1));
  serial_slice_bridge #(.XLEN(32), .SLICE_W(8), .N_IN(3), .N_OUT(1)) u_w8 (
    .clk(clk), .rstn(rstn), .bus(b8));

  bit         lb;
  logic [3:0] rnd_res;

  // Core stand-in: echo operand 0 or return random slices.
  assign bm.core_res = lb ? bm.slice_out[3:0] : rnd_res;
  assign b1.core_res = b1.slice_out[0:0];
  assign b8.core_res = b8.slice_out[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start(input logic [95:0] ops);
    bm.in_valid = 1'b1;
    bm.in_data  = ops;
    @(negedge clk);
    chk("start_in_ready", bm.in_ready, 1);
    @(posedge clk); #1;
    bm.in_valid = 1'b0;
  endtask

  // Checks n slice cycles starting at idx 0 and returns the expected reassembled word.
  task automatic shift_phase(input logic [95:0] ops, input int n, output logic [31:0] res);
    res = '0;
    for (int i = 0; i < n; i++) begin
      rnd_res = 4'($urandom);
      @(negedge clk);
      chk("sh_act", bm.slice_act, 1);
      chk("sh_idx", bm.slice_idx, i);
      chk("sh_last", bm.slice_last, (i == 7));
      chk("sh_in_ready", bm.in_ready, 0);
      chk("sh_out_valid", bm.out_valid, 0);
      for (int k = 0; k < 3; k++)
        chk("sh_slice", bm.slice_out[k*4 +: 4], ops[k*32 + i*4 +: 4]);
      res[i*4 +: 4] = lb ? ops[i*4 +: 4] : rnd_res;
      @(posedge clk); #1;
      bm.in_valid = (i < n - 1) ? 1'($urandom) : 1'b0;
      bm.in_data  = {$urandom, $urandom, $urandom};
    end
    bm.in_valid = 1'b0;
  endtask

  task automatic done_phase(input logic [31:0] exp, input int hold, input bit nv,
                            input logic [95:0] nops);
    for (int h = 0; h < hold; h++) begin
      bm.out_ready = 1'b0;
      bm.in_valid  = 1'b1;
      bm.in_data   = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk("hold_out_valid", bm.out_valid, 1);
      chk("hold_out_data", bm.out_data, exp);
      chk("hold_in_ready", bm.in_ready, 0);
      chk("hold_act", bm.slice_act, 0);
      @(posedge clk); #1;
    end
    bm.out_ready = 1'b1;
    bm.in_valid  = nv;
    bm.in_data   = nops;
    @(negedge clk);
    chk("done_out_valid", bm.out_valid, 1);
    chk("done_out_data", bm.out_data, exp);
    chk("done_in_ready", bm.in_ready, 1);
    @(posedge clk); #1;
    bm.out_ready = 1'b0;
    bm.in_valid  = 1'b0;
    if (!nv) begin
      @(negedge clk);
      chk("idle_out_valid", bm.out_valid, 0);
      chk("idle_in_ready", bm.in_ready, 1);
      chk("idle_act", bm.slice_act, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic sweep1(input logic [95:0] ops);
    int n = 0;
    bit seen = 0;
    b1.in_data  = ops;
    b1.in_valid = 1'b1;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (b1.out_valid) seen = 1;
      else if (b1.slice_act) n++;
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("w1_done", seen, 1);
    chk("w1_nslices", n, 32);
    chk("w1_out_data", b1.out_data, ops[31:0]);
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    b1.out_ready = 1'b0;
  endtask

  task automatic sweep8(input logic [95:0] ops);
    int n = 0;
    bit seen = 0;
    b8.in_data  = ops;
    b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (b8.out_valid) seen = 1;
      else if (b8.slice_act) n++;
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("w8_done", seen, 1);
    chk("w8_nslices", n, 4);
    chk("w8_out_data", b8.out_data, ops[31:0]);
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
  endtask

  initial begin
    logic [95:0] ops, nops;
    logic [31:0] r, rx;
    bit          b2b;

    rstn = 1'b0;
    lb   = 1'b1;
    rnd_res = '0;
    bm.in_valid = 1'b0; bm.in_data = '0; bm.abort = 1'b0; bm.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.abort = 1'b0; b1.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.abort = 1'b0; b8.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bm.in_ready, 1);
    chk("rst_act", bm.slice_act, 0);
    chk("rst_idx", bm.slice_idx, 0);
    chk("rst_out_valid", bm.out_valid, 0);
    chk("rst_out_data", bm.out_data, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Fixed operands with loopback, result held 5 cycles.
    ops = {32'hDEADBEEF, 32'h00001000, 32'h12345678};
    start(ops);
    shift_phase(ops, 8, r);
    done_phase(r, 5, 1'b0, '0);

    // Back-to-back: second transaction accepted in DONE, random core results.
    ops  = {$urandom, $urandom, $urandom};
    nops = {$urandom, $urandom, $urandom};
    start(ops);
    shift_phase(ops, 8, r);
    done_phase(r, 0, 1'b1, nops);
    lb = 1'b0;
    shift_phase(nops, 8, r);
    done_phase(r, 2, 1'b0, '0);
    lb = 1'b1;

    // Abort at idx 3 with a coincident in_valid.
    ops = {$urandom, $urandom, $urandom};
    start(ops);
    shift_phase(ops, 3, rx);
    bm.abort = 1'b1;
    bm.in_valid = 1'b1;
    bm.in_data = {$urandom, $urandom, $urandom};
    @(negedge clk);
    chk("ab_idx", bm.slice_idx, 3);
    chk("ab_in_ready", bm.in_ready, 0);
    @(posedge clk); #1;
    bm.abort = 1'b0;
    bm.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("ab_out_valid", bm.out_valid, 0);
      chk("ab_act", bm.slice_act, 0);
      chk("ab_idx0", bm.slice_idx, 0);
      chk("ab_in_ready_idle", bm.in_ready, 1);
      @(posedge clk); #1;
    end
    ops = {$urandom, $urandom, $urandom};
    start(ops);
    shift_phase(ops, 8, r);
    done_phase(r, 1, 1'b0, '0);

    // Reset asserted at idx 5.
    ops = {$urandom | 32'h1, $urandom | 32'h1, $urandom | 32'h1};
    start(ops);
    shift_phase(ops, 5, rx);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("mr_in_ready", bm.in_ready, 1);
    chk("mr_act", bm.slice_act, 0);
    chk("mr_idx", bm.slice_idx, 0);
    chk("mr_last", bm.slice_last, 0);
    chk("mr_out_valid", bm.out_valid, 0);
    chk("mr_out_data", bm.out_data, 0);
    chk("mr_slice_out", bm.slice_out, 0);
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      ops  = {$urandom, $urandom, $urandom};
      nops = {$urandom, $urandom, $urandom};
      lb   = 1'($urandom_range(0, 1));
      b2b  = 1'($urandom_range(0, 1));
      start(ops);
      shift_phase(ops, 8, r);
      done_phase(r, $urandom_range(0, 3), b2b, nops);
      if (b2b) begin
        shift_phase(nops, 8, r);
        done_phase(r, 1, 1'b0, '0);
      end
    end

    for (int t = 0; t < 3; t++) begin
      sweep1({$urandom, $urandom, $urandom});
      sweep8({$urandom, $urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
    $finish;
  end

endmodule
